// File: rtl/stream_packer.sv
// Narrow-to-wide stream upsizer: packs NumBeats input beats into one registered
// output word, with in_last_i closing a partial word early and a per-lane mask.
module stream_packer #(
    parameter int DataWidth = 32,
    parameter int NumBeats  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DataWidth-1:0]          in_data_i,
    input  logic                          in_last_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [DataWidth*NumBeats-1:0] out_data_o,
    output logic [NumBeats-1:0]           out_mask_o,
    output logic                          out_last_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i
);

    localparam int CntW = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam logic [CntW-1:0] LastLane = CntW'(NumBeats - 1);

    if (NumBeats < 2) begin : g_bad_num_beats
        $error("stream_packer: NumBeats must be at least 2");
    end

    logic [NumBeats-1:0][DataWidth-1:0] data_q;
    logic [NumBeats-1:0]                mask_q;
    logic [CntW-1:0]                    cnt_q;
    logic                               last_q;
    logic                               out_valid_q;

    logic in_hs;
    logic out_hs;
    logic word_done;

    // A finished word blocks input only until the consumer takes it.
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign in_hs      = in_valid_i && in_ready_o;
    assign out_hs     = out_valid_q && out_ready_i;
    assign word_done  = in_hs && ((cnt_q == LastLane) || in_last_i);

    // NOTE: the lane registers are reset too, so out_data_o reads zero after reset
    // and unfilled lanes of a partial word are guaranteed zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q      <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking writes later in this block override the clear
            // above them, so a beat accepted in the drain cycle lands on a clean word.
            if (out_hs) begin
                data_q <= '0;
                mask_q <= '0;
            end
            if (in_hs) begin
                data_q[cnt_q] <= in_data_i;
                mask_q[cnt_q] <= 1'b1;
                cnt_q         <= word_done ? '0 : cnt_q + 1'b1;
            end
            if (word_done) begin
                out_valid_q <= 1'b1;
                last_q      <= in_last_i;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data_o  = data_q;
    assign out_mask_o  = mask_q;
    assign out_last_o  = last_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer: a NumBeats=2 and a NumBeats=4 instance,
// plus a scoreboarded random stream on the 4-lane instance.
module tb_stream_packer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]  d2_in_data;
    logic         d2_in_last, d2_in_valid, d2_in_ready;
    logic [63:0]  d2_out_data;
    logic [1:0]   d2_out_mask;
    logic         d2_out_last, d2_out_valid, d2_out_ready;

    logic [31:0]  d4_in_data;
    logic         d4_in_last, d4_in_valid, d4_in_ready;
    logic [127:0] d4_out_data;
    logic [3:0]   d4_out_mask;
    logic         d4_out_last, d4_out_valid, d4_out_ready;

    stream_packer #(.DataWidth(32), .NumBeats(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(d2_in_data), .in_last_i(d2_in_last), .in_valid_i(d2_in_valid),
        .in_ready_o(d2_in_ready),
        .out_data_o(d2_out_data), .out_mask_o(d2_out_mask), .out_last_o(d2_out_last),
        .out_valid_o(d2_out_valid), .out_ready_i(d2_out_ready)
    );

    stream_packer #(.DataWidth(32), .NumBeats(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(d4_in_data), .in_last_i(d4_in_last), .in_valid_i(d4_in_valid),
        .in_ready_o(d4_in_ready),
        .out_data_o(d4_out_data), .out_mask_o(d4_out_mask), .out_last_o(d4_out_last),
        .out_valid_o(d4_out_valid), .out_ready_i(d4_out_ready)
    );

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   mask;
        logic         last;
    } word_t;

    int checks = 0;
    int errors = 0;

    word_t        exp_q[$];
    logic [127:0] cur_data;
    logic [3:0]   cur_mask;
    int           cur_cnt;
    int           words_seen;
    int           beats_in;
    int           beats_out;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called a few ns before the rising edge: scores the handshakes about to happen.
    task automatic sb_step();
        word_t w;
        logic  in_hs;
        logic  out_hs;
        in_hs  = d4_in_valid && d4_in_ready;
        out_hs = d4_out_valid && d4_out_ready;
        if (out_hs) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 128'(1), 128'(0));
            end else begin
                w = exp_q.pop_front();
                check("sb_data", d4_out_data, w.data);
                check("sb_mask", 128'(d4_out_mask), 128'(w.mask));
                check("sb_last", 128'(d4_out_last), 128'(w.last));
            end
            words_seen++;
            beats_out += $countones(d4_out_mask);
        end
        if (in_hs) begin
            cur_data[cur_cnt*32 +: 32] = d4_in_data;
            cur_mask[cur_cnt]          = 1'b1;
            beats_in++;
            if (cur_cnt == 3 || d4_in_last) begin
                w.data = cur_data;
                w.mask = cur_mask;
                w.last = d4_in_last;
                exp_q.push_back(w);
                cur_data = '0;
                cur_mask = '0;
                cur_cnt  = 0;
            end else begin
                cur_cnt++;
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        d2_in_valid  = 1'b1;
        d2_in_data   = 32'hDEAD_BEEF;
        d2_in_last   = 1'b0;
        d2_out_ready = 1'b0;
        d4_in_valid  = 1'b0;
        d4_in_data   = '0;
        d4_in_last   = 1'b0;
        d4_out_ready = 1'b0;
        cur_data     = '0;
        cur_mask     = '0;
        cur_cnt      = 0;
        words_seen   = 0;
        beats_in     = 0;
        beats_out    = 0;

        // Reset with a valid beat present: nothing captured, ready stays high.
        #1;
        check("rst_in_ready", 128'(d2_in_ready), 128'(1));
        repeat (2) tick();
        check("rst_out_valid", 128'(d2_out_valid), 128'(0));
        check("rst_out_mask", 128'(d2_out_mask), 128'(0));
        check("rst_out_data", 128'(d2_out_data), 128'(0));
        check("rst_out_last", 128'(d2_out_last), 128'(0));
        check("rst_in_ready_held", 128'(d2_in_ready), 128'(1));
        rst         = 1'b0;
        d2_in_valid = 1'b0;
        tick();
        check("post_rst_valid", 128'(d2_out_valid), 128'(0));
        check("post_rst_mask", 128'(d2_out_mask), 128'(0));
        check("post_rst_ready", 128'(d2_in_ready), 128'(1));

        // Full pack, two lanes.
        d2_out_ready = 1'b1;
        d2_in_valid  = 1'b1;
        d2_in_data   = 32'h1111_1111;
        tick();
        check("pack_mid_valid", 128'(d2_out_valid), 128'(0));
        d2_in_data = 32'h2222_2222;
        tick();
        check("pack_valid", 128'(d2_out_valid), 128'(1));
        check("pack_data", 128'(d2_out_data), 128'(64'h2222_2222_1111_1111));
        check("pack_mask", 128'(d2_out_mask), 128'(2'b11));
        check("pack_last", 128'(d2_out_last), 128'(0));
        d2_in_valid = 1'b0;
        tick();
        check("pack_drained", 128'(d2_out_valid), 128'(0));

        // Backpressure: word held stable, input stalled.
        d2_out_ready = 1'b0;
        d2_in_valid  = 1'b1;
        d2_in_data   = 32'h3333_3333;
        tick();
        check("bp_fill_ready", 128'(d2_in_ready), 128'(1));
        d2_in_data = 32'h4444_4444;
        tick();
        d2_in_data = 32'h5555_5555;
        for (int i = 0; i < 10; i++) begin
            check("bp_in_ready", 128'(d2_in_ready), 128'(0));
            check("bp_valid", 128'(d2_out_valid), 128'(1));
            check("bp_data", 128'(d2_out_data), 128'(64'h4444_4444_3333_3333));
            check("bp_mask", 128'(d2_out_mask), 128'(2'b11));
            tick();
        end
        d2_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 128'(d2_in_ready), 128'(1));
        tick();
        check("bp_new_valid", 128'(d2_out_valid), 128'(0));
        check("bp_new_mask", 128'(d2_out_mask), 128'(2'b01));
        check("bp_new_data", 128'(d2_out_data), 128'(64'h0000_0000_5555_5555));
        d2_in_data = 32'h6666_6666;
        d2_in_last = 1'b1;
        tick();
        check("last_full_valid", 128'(d2_out_valid), 128'(1));
        check("last_full_data", 128'(d2_out_data), 128'(64'h6666_6666_5555_5555));
        check("last_full_mask", 128'(d2_out_mask), 128'(2'b11));
        check("last_full_last", 128'(d2_out_last), 128'(1));

        // Single-beat words completing in the same cycle as a drain.
        d2_in_data = 32'h7777_7777;
        tick();
        check("one_lane_valid", 128'(d2_out_valid), 128'(1));
        check("one_lane_data", 128'(d2_out_data), 128'(64'h0000_0000_7777_7777));
        check("one_lane_mask", 128'(d2_out_mask), 128'(2'b01));
        check("one_lane_last", 128'(d2_out_last), 128'(1));
        d2_in_data = 32'h8888_8888;
        tick();
        check("replace_valid", 128'(d2_out_valid), 128'(1));
        check("replace_data", 128'(d2_out_data), 128'(64'h0000_0000_8888_8888));
        check("replace_mask", 128'(d2_out_mask), 128'(2'b01));
        d2_in_valid = 1'b0;
        d2_in_last  = 1'b0;
        tick();
        check("replace_drained", 128'(d2_out_valid), 128'(0));

        // Early last on the four-lane instance.
        d4_out_ready = 1'b1;
        d4_in_valid  = 1'b1;
        d4_in_data   = 32'h0000_000A;
        tick();
        d4_in_data = 32'h0000_000B;
        d4_in_last = 1'b1;
        tick();
        check("early_valid", 128'(d4_out_valid), 128'(1));
        check("early_mask", 128'(d4_out_mask), 128'(4'b0011));
        check("early_data", d4_out_data, 128'h0000_0000_0000_0000_0000_000B_0000_000A);
        check("early_last", 128'(d4_out_last), 128'(1));
        d4_in_data = 32'h0000_000C;
        d4_in_last = 1'b0;
        tick();
        check("next_valid", 128'(d4_out_valid), 128'(0));
        check("next_mask", 128'(d4_out_mask), 128'(4'b0001));
        check("next_data", d4_out_data, 128'h0000_000C);
        d4_in_data = 32'h0000_000D;
        tick();
        d4_in_data = 32'h0000_000E;
        tick();
        d4_in_data = 32'h0000_000F;
        tick();
        check("full4_valid", 128'(d4_out_valid), 128'(1));
        check("full4_mask", 128'(d4_out_mask), 128'(4'b1111));
        check("full4_data", d4_out_data, 128'h0000_000F_0000_000E_0000_000D_0000_000C);
        check("full4_last", 128'(d4_out_last), 128'(0));
        d4_in_valid = 1'b0;
        tick();
        check("full4_drained", 128'(d4_out_valid), 128'(0));

        // Both sides always ready: one beat per cycle, a word every four cycles.
        d4_in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d4_in_data = 32'(i + 1);
            d4_in_last = 1'b0;
            #3;
            check("thru_in_ready", 128'(d4_in_ready), 128'(1));
            sb_step();
            tick();
        end
        d4_in_valid = 1'b0;
        #3;
        sb_step();
        tick();
        check("thru_word_count", 128'(words_seen), 128'(10));

        // Random valid/ready/last stream against the scoreboard.
        for (int i = 0; i < 2000; i++) begin
            d4_in_valid  = ($urandom_range(0, 3) != 0);
            d4_in_data   = $urandom;
            d4_in_last   = ($urandom_range(0, 7) == 0);
            d4_out_ready = ($urandom_range(0, 3) != 0);
            #3;
            sb_step();
            tick();
        end
        d4_out_ready = 1'b1;
        d4_in_valid  = 1'b1;
        d4_in_last   = 1'b1;
        d4_in_data   = 32'hF1F1_F1F1;
        #3;
        sb_step();
        tick();
        d4_in_valid = 1'b0;
        d4_in_last  = 1'b0;
        repeat (3) begin
            #3;
            sb_step();
            tick();
        end
        check("sb_queue_empty", 128'(exp_q.size()), 128'(0));
        check("sb_beats_balanced", 128'(beats_out), 128'(beats_in));
        check("sb_beats_enough", 128'(beats_in >= 1000), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
